// File: rtl/dmem_bus_master_if.sv
// Wishbone classic (B3) data-bus bundle between the core's data-memory master and the SoC slave.
interface dmem_bus_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/dmem_bus_master.sv
// MEM-stage load/store to single Wishbone classic transaction; freezes the pipeline until ack.
// Optional bus timeout with bus_err pulse is built when DMEM_TIMEOUT_EN is defined.
module dmem_bus_master #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_read_mem,
    input  logic          mem_write_mem,
    input  logic [2:0]    fun3_mem,
    input  logic [AW-1:0] addr_mem,
    input  logic [DW-1:0] wdata_mem,
    output logic [DW-1:0] rdata_mem,
    output logic          stall_pipl,
    output logic          bus_err,
    dmem_bus_master_if.master wb
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t        state, state_nxt;
    logic          req, start, done_ok;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] dat_q;
    logic [3:0]    sel_q;
    logic          we_q;
    logic [2:0]    fun3_q;
    logic [1:0]    lane_q;

    function automatic logic [3:0] sel_of(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DW-1:0] lanes_of(input logic [1:0] size, input logic [DW-1:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [DW-1:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [DW-1:0] d);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = d[{a, 3'b000} +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  return DW'(b);
            3'b001:  return DW'(h);
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return d;
        endcase
    endfunction

    assign req        = mem_read_mem | mem_write_mem;
    assign stall_pipl = ((state == IDLE) && req) || (state == BUS);

    // cyc/stb come straight from the state register so an async reset drops them at once
    assign wb.wb_cyc_o = (state == BUS);
    assign wb.wb_stb_o = (state == BUS);
    assign wb.wb_we_o  = we_q;
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = sel_q;

`ifdef DMEM_TIMEOUT_EN
    logic [7:0] cnt;
    logic       timeout;
    logic       err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= timeout;
            if (start)
                cnt <= '0;
            else if ((state == BUS) && !wb.wb_ack_i)
                cnt <= cnt + 8'd1;
        end
    end

    assign bus_err = err_q;
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        done_ok   = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        timeout   = 1'b0;
`endif
        case (state)
            IDLE: if (req) begin
                start     = 1'b1;
                state_nxt = BUS;
            end
            BUS: begin
                // ack wins over a timeout landing in the same cycle
                if (wb.wb_ack_i) begin
                    done_ok   = 1'b1;
                    state_nxt = DONE;
                end
`ifdef DMEM_TIMEOUT_EN
                else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = DONE;
                end
`endif
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            fun3_q    <= '0;
            lane_q    <= '0;
            rdata_mem <= '0;
        end else begin
            if (start) begin
                adr_q  <= {addr_mem[AW-1:2], 2'b00};
                dat_q  <= lanes_of(fun3_mem[1:0], wdata_mem);
                sel_q  <= sel_of(fun3_mem[1:0], addr_mem[1:0]);
                we_q   <= mem_write_mem;
                fun3_q <= fun3_mem;
                lane_q <= addr_mem[1:0];
            end
            if (done_ok && !we_q)
                rdata_mem <= load_ext(fun3_q, lane_q, wb.wb_dat_i);
`ifdef DMEM_TIMEOUT_EN
            if (timeout)
                rdata_mem <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_bus_master.sv
// Directed bench for dmem_bus_master: loads, stores, back-to-back, async reset, optional timeout.
module tb_dmem_bus_master;

`ifdef DMEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_mem, mem_write_mem;
    logic [2:0]  fun3_mem;
    logic [31:0] addr_mem, wdata_mem, rdata_mem;
    logic        stall_pipl, bus_err;

    int passed = 0;
    int total  = 0;
    int txn_cnt = 0;

    logic [3:0]  cap_sel;
    logic [31:0] cap_adr, cap_dat;
    logic        cap_we;

    dmem_bus_master_if #(.AW(32), .DW(32)) wb ();

    dmem_bus_master #(.AW(32), .DW(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_read_mem  (mem_read_mem),
        .mem_write_mem (mem_write_mem),
        .fun3_mem      (fun3_mem),
        .addr_mem      (addr_mem),
        .wdata_mem     (wdata_mem),
        .rdata_mem     (rdata_mem),
        .stall_pipl    (stall_pipl),
        .bus_err       (bus_err),
        .wb            (wb.master)
    );

    always #5 clk = ~clk;

    always @(posedge wb.wb_cyc_o) txn_cnt++;

    // Drives one access and plays the slave; returns at the first DONE sample (req still held).
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] din, input int waits, output int stalls);
        int bus_cyc;
        bit seen;
        bus_cyc = 0;
        seen    = 0;
        stalls  = 0;
        @(negedge clk);
        mem_read_mem  = rd;
        mem_write_mem = wr;
        fun3_mem      = f3;
        addr_mem      = a;
        wdata_mem     = wd;
        wb.wb_dat_i   = din;
        wb.wb_ack_i   = 1'b0;
        for (int i = 0; i < 600; i++) begin
            #1;
            if (stall_pipl) begin
                stalls++;
                seen = 1;
            end else if (seen) begin
                wb.wb_ack_i = 1'b0;
                return;
            end
            if (wb.wb_cyc_o) begin
                bus_cyc++;
                cap_sel = wb.wb_sel_o;
                cap_adr = wb.wb_adr_o;
                cap_dat = wb.wb_dat_o;
                cap_we  = wb.wb_we_o;
                wb.wb_ack_i = (bus_cyc > waits);
            end else begin
                wb.wb_ack_i = 1'b0;
            end
            @(negedge clk);
        end
        stalls = -1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        mem_read_mem  = 1'b0;
        mem_write_mem = 1'b0;
        wb.wb_ack_i   = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_read_mem = 1'b0; mem_write_mem = 1'b0; fun3_mem = 3'b000;
        addr_mem = 32'h0; wdata_mem = 32'h0;
        wb.wb_dat_i = 32'h0; wb.wb_ack_i = 1'b0;
        #12;
        total++; if (wb.wb_cyc_o !== 1'b0) $display("FAIL reset_cyc: got %b want 0", wb.wb_cyc_o); else passed++;
        total++; if (wb.wb_stb_o !== 1'b0) $display("FAIL reset_stb: got %b want 0", wb.wb_stb_o); else passed++;
        total++; if (wb.wb_we_o !== 1'b0) $display("FAIL reset_we: got %b want 0", wb.wb_we_o); else passed++;
        total++; if (wb.wb_adr_o !== 32'h0) $display("FAIL reset_adr: got %h want 0", wb.wb_adr_o); else passed++;
        total++; if (wb.wb_dat_o !== 32'h0) $display("FAIL reset_dat: got %h want 0", wb.wb_dat_o); else passed++;
        total++; if (wb.wb_sel_o !== 4'h0) $display("FAIL reset_sel: got %b want 0", wb.wb_sel_o); else passed++;
        total++; if (rdata_mem !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata_mem); else passed++;
        total++; if (bus_err !== 1'b0) $display("FAIL reset_bus_err: got %b want 0", bus_err); else passed++;
        total++; if (stall_pipl !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_pipl); else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_lw();
        int st;
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, st);
        total++; if (st !== 2) $display("FAIL lw_stalls: got %0d want 2", st); else passed++;
        total++; if (cap_sel !== 4'b1111) $display("FAIL lw_sel: got %b want 1111", cap_sel); else passed++;
        total++; if (cap_adr !== 32'h100) $display("FAIL lw_adr: got %h want 00000100", cap_adr); else passed++;
        total++; if (cap_we !== 1'b0) $display("FAIL lw_we: got %b want 0", cap_we); else passed++;
        total++; if (rdata_mem !== 32'hDEADBEEF) $display("FAIL lw_rdata: got %h want deadbeef", rdata_mem); else passed++;
        total++; if (wb.wb_cyc_o !== 1'b0) $display("FAIL lw_cyc_done: got %b want 0", wb.wb_cyc_o); else passed++;
        idle(2);
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3  [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b011, 3'b110};
        logic [31:0] ad  [7] = '{32'h103, 32'h103, 32'h102, 32'h001, 32'h101, 32'h102, 32'h003};
        logic [31:0] din [7] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80011234, 32'h12348765,
                                 32'h00007F00, 32'hCAFEF00D, 32'h12345678};
        logic [3:0]  es  [7] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0010, 4'b1111, 4'b1111};
        logic [31:0] ea  [7] = '{32'h100, 32'h100, 32'h100, 32'h000, 32'h100, 32'h100, 32'h000};
        logic [31:0] er  [7] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008765,
                                 32'h0000007F, 32'hCAFEF00D, 32'h12345678};
        int st;
        for (int k = 0; k < 7; k++) begin
            run_access(1'b1, 1'b0, f3[k], ad[k], 32'h0, din[k], k % 2, st);
            total++; if (st !== 2 + (k % 2)) $display("FAIL ld%0d_stalls: got %0d want %0d", k, st, 2 + (k % 2)); else passed++;
            total++; if (cap_sel !== es[k]) $display("FAIL ld%0d_sel: got %b want %b", k, cap_sel, es[k]); else passed++;
            total++; if (cap_adr !== ea[k]) $display("FAIL ld%0d_adr: got %h want %h", k, cap_adr, ea[k]); else passed++;
            total++; if (rdata_mem !== er[k]) $display("FAIL ld%0d_rdata: got %h want %h", k, rdata_mem, er[k]); else passed++;
            idle(1);
        end
    endtask

    task automatic test_store();
        logic        rd  [3] = '{1'b0, 1'b0, 1'b1};
        logic [2:0]  f3  [3] = '{3'b001, 3'b000, 3'b010};
        logic [31:0] ad  [3] = '{32'h202, 32'h201, 32'h030};
        logic [31:0] wd  [3] = '{32'h0000ABCD, 32'h123456EF, 32'h11223344};
        int          wt  [3] = '{3, 1, 0};
        logic [3:0]  es  [3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] ea  [3] = '{32'h200, 32'h200, 32'h030};
        logic [31:0] ed  [3] = '{32'hABCDABCD, 32'hEFEFEFEF, 32'h11223344};
        int st;
        run_access(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 32'h13579BDF, 0, st);
        idle(1);
        for (int k = 0; k < 3; k++) begin
            run_access(rd[k], 1'b1, f3[k], ad[k], wd[k], 32'hFFFFFFFF, wt[k], st);
            total++; if (st !== wt[k] + 2) $display("FAIL st%0d_stalls: got %0d want %0d", k, st, wt[k] + 2); else passed++;
            total++; if (cap_we !== 1'b1) $display("FAIL st%0d_we: got %b want 1", k, cap_we); else passed++;
            total++; if (cap_sel !== es[k]) $display("FAIL st%0d_sel: got %b want %b", k, cap_sel, es[k]); else passed++;
            total++; if (cap_adr !== ea[k]) $display("FAIL st%0d_adr: got %h want %h", k, cap_adr, ea[k]); else passed++;
            total++; if (cap_dat !== ed[k]) $display("FAIL st%0d_dat: got %h want %h", k, cap_dat, ed[k]); else passed++;
            total++; if (rdata_mem !== 32'h13579BDF) $display("FAIL st%0d_rdata: got %h want 13579bdf", k, rdata_mem); else passed++;
            total++; if (bus_err !== 1'b0) $display("FAIL st%0d_bus_err: got %b want 0", k, bus_err); else passed++;
            idle(1);
        end
    endtask

    task automatic test_back_to_back();
        int st1, st2, t0;
        t0 = txn_cnt;
        run_access(1'b1, 1'b0, 3'b010, 32'h010, 32'h0, 32'h00000001, 0, st1);
        run_access(1'b1, 1'b0, 3'b000, 32'h011, 32'h0, 32'h0000AB00, 0, st2);
        total++; if (st1 !== 2) $display("FAIL b2b_stalls1: got %0d want 2", st1); else passed++;
        total++; if (st2 !== 2) $display("FAIL b2b_stalls2: got %0d want 2", st2); else passed++;
        total++; if (rdata_mem !== 32'hFFFFFFAB) $display("FAIL b2b_rdata: got %h want ffffffab", rdata_mem); else passed++;
        idle(3);
        total++; if (txn_cnt - t0 !== 2) $display("FAIL b2b_txns: got %0d want 2", txn_cnt - t0); else passed++;
    endtask

    task automatic test_ack_outside();
        int st;
        run_access(1'b1, 1'b0, 3'b010, 32'h040, 32'h0, 32'h0BADF00D, 0, st);
        idle(1);
        wb.wb_dat_i = 32'h55AA55AA;
        wb.wb_ack_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (wb.wb_cyc_o !== 1'b0) $display("FAIL ackout_cyc: got %b want 0", wb.wb_cyc_o); else passed++;
        total++; if (stall_pipl !== 1'b0) $display("FAIL ackout_stall: got %b want 0", stall_pipl); else passed++;
        total++; if (rdata_mem !== 32'h0BADF00D) $display("FAIL ackout_rdata: got %h want 0badf00d", rdata_mem); else passed++;
        wb.wb_ack_i = 1'b0;
    endtask

    task automatic test_async_reset();
        int st;
        @(negedge clk);
        mem_read_mem = 1'b1; mem_write_mem = 1'b0; fun3_mem = 3'b010; addr_mem = 32'h080;
        wb.wb_ack_i = 1'b0;
        @(negedge clk);
        #1;
        total++; if (wb.wb_cyc_o !== 1'b1) $display("FAIL arst_cyc_bus: got %b want 1", wb.wb_cyc_o); else passed++;
        reset = 1'b1;
        #1;
        total++; if (wb.wb_cyc_o !== 1'b0) $display("FAIL arst_cyc_drop: got %b want 0", wb.wb_cyc_o); else passed++;
        total++; if (wb.wb_stb_o !== 1'b0) $display("FAIL arst_stb_drop: got %b want 0", wb.wb_stb_o); else passed++;
        total++; if (rdata_mem !== 32'h0) $display("FAIL arst_rdata: got %h want 0", rdata_mem); else passed++;
        mem_read_mem = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        total++; if (stall_pipl !== 1'b0) $display("FAIL arst_stall: got %b want 0", stall_pipl); else passed++;
        total++; if (wb.wb_cyc_o !== 1'b0) $display("FAIL arst_cyc_idle: got %b want 0", wb.wb_cyc_o); else passed++;
        run_access(1'b1, 1'b0, 3'b010, 32'h084, 32'h0, 32'h600DCAFE, 0, st);
        total++; if (st !== 2) $display("FAIL arst_recover_stalls: got %0d want 2", st); else passed++;
        total++; if (rdata_mem !== 32'h600DCAFE) $display("FAIL arst_recover_rdata: got %h want 600dcafe", rdata_mem); else passed++;
        idle(1);
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        int st;
        run_access(1'b1, 1'b0, 3'b010, 32'h040, 32'h0, 32'h00000055, 0, st);
        idle(1);
        run_access(1'b1, 1'b0, 3'b010, 32'h044, 32'h0, 32'hFFFFFFFF, 1000, st);
        total++; if (st !== 5) $display("FAIL to_stalls: got %0d want 5", st); else passed++;
        total++; if (bus_err !== 1'b1) $display("FAIL to_bus_err: got %b want 1", bus_err); else passed++;
        total++; if (rdata_mem !== 32'h0) $display("FAIL to_rdata: got %h want 0", rdata_mem); else passed++;
        total++; if (wb.wb_cyc_o !== 1'b0) $display("FAIL to_cyc: got %b want 0", wb.wb_cyc_o); else passed++;
        idle(1);
        #1;
        total++; if (bus_err !== 1'b0) $display("FAIL to_bus_err_pulse: got %b want 0", bus_err); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_back_to_back();
        test_ack_outside();
        test_async_reset();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_bus_master.md
Name: dmem_bus_master

Overview:
- Data-memory side of the core's `stall_pipl` interface: the block that generates the `stall_pipl` signal the control unit consumes.
- Takes the MEM-stage load/store, runs it as a single Wishbone classic (B3) master transaction and holds the pipeline frozen until the bus acknowledges.
- Returns load data, already sign- or zero-extended, to the MEM/WB path.
- Sits between the core's MEM stage and the SoC data bus.

Parameters:
- AW, 32, bus address width.
- DW, 32, bus data width; only 32 is supported.
- TIMEOUT_CYCLES, 255, maximum BUS-state cycles before abort (used only with the optional feature).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- mem_read_mem  in  1  MEM-stage instruction is a load.
- mem_write_mem  in  1  MEM-stage instruction is a store.
- fun3_mem  in  3  access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; sb/sh/sw use 000/001/010.
- addr_mem  in  AW  byte address.
- wdata_mem  in  DW  store data, right-aligned.
- rdata_mem  out  DW  extended load result.
- stall_pipl  out  1  freeze request to the pipeline controller.
- bus_err  out  1  one-cycle pulse on a timed-out access.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master controls.
- wb_adr_o  out  AW  word-aligned address (low 2 bits zero).
- wb_dat_o  out  DW  store data, lane-replicated.
- wb_sel_o  out  4  byte enables.
- wb_dat_i  in  DW  read data.
- wb_ack_i  in  1  slave acknowledge.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `reset` is asynchronous and active-high.
- Reset values: state IDLE; `wb_cyc_o`/`wb_stb_o`/`wb_we_o` = 0; `wb_adr_o`/`wb_dat_o`/`wb_sel_o` = 0; `rdata_mem` = 0; `bus_err` = 0.
- A request is `req` = `mem_read_mem` | `mem_write_mem`. If both are high, the access is a store.
- FSM states: IDLE, BUS, DONE.
  - IDLE & `req`: register address, `we`, `sel`, write data and `fun3`, then go to BUS.
  - BUS: `wb_cyc_o` = `wb_stb_o` = 1 and all bus outputs stay stable. On `wb_ack_i`, capture the extended load data into `rdata_mem`, deassert `cyc`/`stb` on the next edge and go to DONE.
  - DONE: for one cycle, ignore `req`; the same instruction is still in MEM. Then return to IDLE unconditionally.
- `stall_pipl` is combinational: (IDLE & `req`) | BUS. It is 0 in DONE, so the pipeline advances at the end of DONE.
- Minimum latency: 2 stall cycles (request cycle, then BUS with immediate ack); `rdata_mem` is valid in DONE. Each extra cycle without ack adds one stall cycle.
- `wb_sel_o` (no misalignment trap):
  - Byte: 0001 << `addr[1:0]`.
  - Half: 0011 << {`addr[1]`, 0}; `addr[0]` is ignored.
  - Word: 1111; `addr[1:0]` is ignored.
- `wb_dat_o`:
  - Byte: store byte replicated ×4.
  - Half: store half replicated ×2.
  - Word: store word as is.
- Loads:
  - Select the lane using the registered `addr[1:0]`.
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - Undefined `fun3` encodings behave as lw.
- Stores leave `rdata_mem` unchanged.
- `wb_ack_i` outside BUS is ignored.
- Asynchronous reset during BUS drops `cyc`/`stb` immediately, returns the FSM to IDLE, and the transaction is lost.

Optional Feature:
- Macro: `DMEM_TIMEOUT_EN`.
- When defined:
  - An 8-bit counter clears on entering BUS and increments each BUS cycle without ack.
  - When the counter reaches `TIMEOUT_CYCLES`: drop `cyc`/`stb`, set `rdata_mem` = 0, go to DONE, and pulse `bus_err` = 1 during DONE.
  - An ack in the same cycle as the counter reaching `TIMEOUT_CYCLES` takes precedence: normal completion, no error.
- When not defined:
  - No counter is built; BUS waits for ack indefinitely.
  - `bus_err` is tied to 0.

Test Plan:
- lw at 0x100, slave acks in the first BUS cycle with 0xDEADBEEF -> `stall_pipl` high for exactly 2 cycles, `wb_sel_o` = 1111, `wb_adr_o` = 0x100, `rdata_mem` = 0xDEADBEEF in DONE.
- lb at 0x103, `wb_dat_i` = 0x80FF_FFFF -> `wb_sel_o` = 1000, `rdata_mem` = 0xFFFFFF80. Same access as lbu -> `rdata_mem` = 0x00000080.
- sh at 0x202 with data 0x0000ABCD, ack after 3 wait cycles -> `wb_we_o` = 1, `wb_sel_o` = 1100, `wb_dat_o` = 0xABCDABCD, 5 stall cycles, `rdata_mem` unchanged.
- `req` held high through DONE, followed by a back-to-back load in the next instruction -> exactly 2 bus transactions, no relaunch in DONE.
- `reset` asserted mid-BUS -> `wb_cyc_o`/`wb_stb_o` = 0 immediately (asynchronously), `stall_pipl` = 0 after release with no `req`.
- With `DMEM_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4, slave never acks -> `cyc` drops after 4 BUS cycles, `bus_err` pulses for one cycle, `rdata_mem` = 0.
